// File: rtl/ram_loader.sv
// Purpose : streams DEPTH host bytes into the computer's RAM over the shared bus while the CPU is halted.
// Latency : 3 cycles per byte (accept, ADDR strobe, WRITE strobe); one done pulse after the last write.
// Backpr. : in_ready high only while waiting for a byte; the source holds in_data/in_valid until accepted.
// Ports   : clk/rst (async active-low); start/abort control; in_data/in_valid/in_ready byte stream;
//           bus (tri-stated unless strobing); MI/RI memory strobes; halt/busy session status; done pulse.
module ram_loader #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   inout  wire  [7:0] bus,
   output logic       MI,
   output logic       RI,
   output logic       halt,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_BYTE,
      ADDR,
      WRITE,
      DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        byte_q, byte_d;
   logic              bus_en;
   logic [7:0]        bus_dat;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         byte_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         byte_q  <= byte_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      byte_d   = byte_q;
      in_ready = 1'b0;
      MI       = 1'b0;
      RI       = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;
      bus_en   = 1'b0;
      bus_dat  = 8'h00;

      case (state_q)
         IDLE: begin
            busy = 1'b0;
            // A start coinciding with abort is treated as cancelled before it began.
            if (start && !abort) begin
               state_d = WAIT_BYTE;
               addr_d  = '0;
            end
         end
         WAIT_BYTE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               byte_d  = in_data;
               state_d = ADDR;
            end
         end
         ADDR: begin
            MI      = 1'b1;
            bus_en  = 1'b1;
            bus_dat = 8'(addr_q);
            state_d = WRITE;
         end
         WRITE: begin
            RI      = 1'b1;
            bus_en  = 1'b1;
            bus_dat = byte_q;
            // Finish on the last address instead of incrementing, so the counter never wraps.
            if (addr_q == LAST_ADDR) begin
               state_d = DONE;
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               state_d = WAIT_BYTE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            busy    = 1'b0;
            state_d = IDLE;
         end
      endcase

      // Abort overrides every transition above, including a byte handshake in the same cycle.
      if (abort && state_q != IDLE) begin
         state_d = IDLE;
         addr_d  = '0;
         byte_d  = byte_q;
      end
   end

   assign halt = busy;
   assign bus  = bus_en ? bus_dat : 8'bz;

endmodule

// File: tb/tb_ram_loader.sv
// Purpose : randomized checks of ram_loader against a session-level reference model, plus a DEPTH=1 build.
// Latency : model expects MI one cycle after a byte is accepted, RI the cycle after, then ready or done.
// Backpr. : the source offers bytes (held or randomly throttled) and advances only on an accepted handshake.
module tb_ram_loader;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst, start, abort, in_valid;
   logic [7:0] in_data;
   wire  [7:0] bus;
   logic       in_ready, MI, RI, halt, busy, done;

   logic       d1_start, d1_abort, d1_in_valid;
   logic [7:0] d1_in_data;
   wire  [7:0] d1_bus;
   logic       d1_in_ready, d1_MI, d1_RI, d1_halt, d1_busy, d1_done;

   always #5 clk = ~clk;

   ram_loader #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .bus(bus), .MI(MI), .RI(RI),
      .halt(halt), .busy(busy), .done(done)
   );

   ram_loader #(.DEPTH(1), .ADDR_W(4)) dut1 (
      .clk(clk), .rst(rst), .start(d1_start), .abort(d1_abort), .in_data(d1_in_data),
      .in_valid(d1_in_valid), .in_ready(d1_in_ready), .bus(d1_bus), .MI(d1_MI), .RI(d1_RI),
      .halt(d1_halt), .busy(d1_busy), .done(d1_done)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Session-level reference: whether a session is open, how many bytes have been written,
   // and how far the byte currently in flight has progressed through its address/data strobes.
   bit         m_active   = 1'b0;
   bit         m_inflight = 1'b0;
   int         m_cnt      = 0;
   int         m_wrote    = 0;
   logic [7:0] m_byte     = 8'h00;
   logic [7:0] ram [DEPTH];
   logic [7:0] last_addr  = 8'h00;
   int         mi_cnt = 0, ri_cnt = 0, done_cnt = 0;
   logic [7:0] src [DEPTH];

   always @(negedge clk) begin : mon
      bit exp_rdy, exp_mi, exp_ri, exp_done;
      if (!rst) begin
         m_active   = 1'b0;
         m_inflight = 1'b0;
      end
      exp_rdy  = m_active && !m_inflight && (m_wrote < DEPTH);
      exp_mi   = m_active && m_inflight && (m_cnt == 1);
      exp_ri   = m_active && m_inflight && (m_cnt == 2);
      exp_done = m_active && !m_inflight && (m_wrote == DEPTH);

      chk_eq("busy", busy, m_active);
      chk_eq("halt", halt, m_active);
      chk_eq("in_ready", in_ready, exp_rdy);
      chk_eq("MI", MI, exp_mi);
      chk_eq("RI", RI, exp_ri);
      chk_eq("done", done, exp_done);
      chk_eq("mi_ri_excl", MI & RI, 0);
      if (MI) begin
         chk_eq("mi_addr", bus, m_wrote);
         chk_eq("addr_range", bus < DEPTH, 1);
         last_addr = bus;
         mi_cnt++;
      end else if (RI) begin
         chk_eq("ri_data", bus, m_byte);
         ram[last_addr[3:0]] = bus;
         ri_cnt++;
      end else begin
         chk_eq("bus_z", bus === 8'hzz, 1);
      end
      if (done) done_cnt++;

      if (rst) begin
         if (!m_active) begin
            if (start && !abort) begin
               m_active   = 1'b1;
               m_wrote    = 0;
               m_inflight = 1'b0;
            end
         end else if (abort) begin
            m_active   = 1'b0;
            m_inflight = 1'b0;
         end else if (exp_done) begin
            m_active = 1'b0;
         end else if (m_inflight) begin
            if (m_cnt == 2) begin
               m_inflight = 1'b0;
               m_wrote++;
            end else begin
               m_cnt++;
            end
         end else if (exp_rdy && in_valid) begin
            m_inflight = 1'b1;
            m_cnt      = 1;
            m_byte     = in_data;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic clear_obs();
      mi_cnt = 0; ri_cnt = 0; done_cnt = 0;
      for (int k = 0; k < DEPTH; k++) ram[k] = 8'hxx;
   endtask

   task automatic feed(input int n, input bit throttle);
      int  i = 0;
      int  guard = 0;
      bit  acc;
      while (i < n && guard < 2000) begin
         in_data  = src[i];
         in_valid = throttle ? ($urandom_range(0, 1) == 1) : 1'b1;
         acc      = in_valid && in_ready && !abort;
         tick();
         if (acc) i++;
         guard++;
      end
      in_valid = 1'b0;
      chk_eq("feed_timeout", guard < 2000, 1);
   endtask

   task automatic wait_idle();
      int g = 0;
      while (busy && g < 100) begin
         tick();
         g++;
      end
      chk_eq("idle_timeout", g < 100, 1);
   endtask

   task automatic check_full_load(input string tag);
      chk_eq({tag, "_mi_cnt"}, mi_cnt, DEPTH);
      chk_eq({tag, "_ri_cnt"}, ri_cnt, DEPTH);
      chk_eq({tag, "_done_cnt"}, done_cnt, 1);
      for (int k = 0; k < DEPTH; k++) chk_eq({tag, "_ram"}, ram[k], src[k]);
   endtask

   initial begin
      int g;
      rst = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      d1_start = 1'b0; d1_abort = 1'b0; d1_in_valid = 1'b0; d1_in_data = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk_eq("rst_in_ready", in_ready, 0);
      chk_eq("rst_MI", MI, 0);
      chk_eq("rst_RI", RI, 0);
      chk_eq("rst_halt", halt, 0);
      chk_eq("rst_busy", busy, 0);
      chk_eq("rst_done", done, 0);
      chk_eq("rst_bus_z", bus === 8'hzz, 1);
      rst = 1'b1;
      tick();

      // Full load with the source always valid.
      src[0] = 8'h13; src[1] = 8'hE0; src[2] = 8'hF0; src[3] = 8'hAB;
      for (int k = 4; k < DEPTH; k++) src[k] = 8'($urandom);
      clear_obs();
      do_start();
      feed(DEPTH, 1'b0);
      wait_idle();
      check_full_load("full");
      chk_eq("full_halt_after", halt, 0);

      // Throttled source.
      for (int k = 0; k < DEPTH; k++) src[k] = 8'($urandom);
      clear_obs();
      do_start();
      feed(DEPTH, 1'b1);
      wait_idle();
      check_full_load("thr");

      // Abort during the address strobe of the sixth byte.
      for (int k = 0; k < DEPTH; k++) src[k] = 8'($urandom);
      clear_obs();
      do_start();
      feed(5, 1'b0);
      g = 0;
      while (!in_ready && g < 20) begin tick(); g++; end
      chk_eq("ab_ready_timeout", g < 20, 1);
      in_data = src[5]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk_eq("ab_in_addr", MI, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk_eq("ab_busy", busy, 0);
      repeat (3) tick();
      chk_eq("ab_ri_cnt", ri_cnt, 5);
      chk_eq("ab_done_cnt", done_cnt, 0);
      clear_obs();
      do_start();
      feed(DEPTH, 1'b1);
      wait_idle();
      check_full_load("reload");

      // Abort while a byte is offered in WAIT_BYTE: nothing accepted.
      clear_obs();
      do_start();
      in_data = 8'h55; in_valid = 1'b1; abort = 1'b1;
      tick();
      abort = 1'b0; in_valid = 1'b0;
      chk_eq("abw_busy", busy, 0);
      repeat (3) tick();
      chk_eq("abw_mi_cnt", mi_cnt, 0);

      // start together with abort in IDLE stays idle; abort alone in IDLE does nothing.
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk_eq("startabort_busy", busy, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk_eq("abort_idle_busy", busy, 0);

      // Async reset between edges while WRITE is active.
      do_start();
      in_data = 8'hA5; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk_eq("ar_in_write", RI, 1);
      #2 rst = 1'b0;
      #1;
      chk_eq("ar_MI", MI, 0);
      chk_eq("ar_RI", RI, 0);
      chk_eq("ar_halt", halt, 0);
      chk_eq("ar_busy", busy, 0);
      chk_eq("ar_bus_z", bus === 8'hzz, 1);
      tick();
      rst = 1'b1;
      repeat (3) tick();
      chk_eq("ar_stays_idle", busy, 0);

      // DEPTH=1 build; start held high mid-session must be ignored.
      d1_start = 1'b1;
      tick();
      chk_eq("d1_ready", d1_in_ready, 1);
      d1_in_data = 8'h5A; d1_in_valid = 1'b1;
      tick();
      d1_in_valid = 1'b0;
      chk_eq("d1_MI", d1_MI, 1);
      chk_eq("d1_addr", d1_bus, 8'h00);
      chk_eq("d1_ready_addr", d1_in_ready, 0);
      tick();
      chk_eq("d1_RI", d1_RI, 1);
      chk_eq("d1_MI_write", d1_MI, 0);
      chk_eq("d1_data", d1_bus, 8'h5A);
      tick();
      chk_eq("d1_done", d1_done, 1);
      chk_eq("d1_busy_done", d1_busy, 1);
      d1_start = 1'b0;
      tick();
      chk_eq("d1_idle", d1_busy, 0);
      chk_eq("d1_done_pulse", d1_done, 0);
      tick();
      chk_eq("d1_no_restart", d1_busy, 0);
      chk_eq("d1_bus_z", d1_bus === 8'hzz, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
